refill_arbiter: RTL and testbench

Arbitrates the single backing `ram` between two cache refill requesters: port 0 for the instruction cache and port 1 for a data cache. Each granted requester receives one block refill, which is a burst of `WORDS` words. The block drives the RAM's read strobe, address and word-select, captures each returned word and hands it to the owner with a valid pulse. It sits between the cache controllers and `ram`, replacing the direct controller-to-ram wiring so that both caches share one memory.

---
 rtl/refill_arbiter_if.sv | 30 +++
 rtl/refill_arbiter.sv | 84 ++++++++
 tb/tb_refill_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/refill_arbiter_if.sv
// Bundle between the two cache refill requesters, the arbiter and the backing RAM.
// The arbiter takes the slave modport; the requester/RAM side takes master.
interface refill_arbiter_if #(
   parameter int unsigned WSEL_W = 1
);
   logic [1:0]        req;
   logic [31:0]       addr0;
   logic [31:0]       addr1;
   logic [1:0]        grant;
   logic [1:0]        rvalid;
   logic [1:0]        done;
   logic [31:0]       rdata;
   logic [WSEL_W-1:0] rword;
   logic              busy;
   logic              mem_rd;
   logic [31:0]       mem_addr;
   logic [WSEL_W-1:0] mem_w_sel;
   logic              mem_ready;
   logic [31:0]       mem_data;

   modport master (
      output req, addr0, addr1, mem_ready, mem_data,
      input  grant, rvalid, done, rdata, rword, busy, mem_rd, mem_addr, mem_w_sel
   );

   modport slave (
      input  req, addr0, addr1, mem_ready, mem_data,
      output grant, rvalid, done, rdata, rword, busy, mem_rd, mem_addr, mem_w_sel
   );
endinterface

// File: rtl/refill_arbiter.sv
// Round-robin arbiter sharing one RAM between two cache refill requesters.
// Each grant runs one WORDS-long read burst, forwarding every word with an rvalid pulse.
module refill_arbiter #(
   parameter int unsigned WORDS  = 2,
   parameter int unsigned WSEL_W = 1
) (
   input logic             clk,
   input logic             reset,
   refill_arbiter_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   localparam logic [WSEL_W-1:0] LastWord = WSEL_W'(WORDS - 1);

   state_e            state_q;
   logic              owner_q;
   logic              last_q;
   logic [WSEL_W-1:0] cnt_q;
   logic              win;

   // A lone request names its own winner; a tie goes to whoever was not served last.
   always_comb begin
      win = bus.req[1];
      if (bus.req == 2'b11) win = ~last_q;
   end

   assign bus.busy      = (state_q != StIdle);
   assign bus.mem_w_sel = cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         owner_q      <= 1'b0;
         last_q       <= 1'b1;
         cnt_q        <= '0;
         bus.grant    <= '0;
         bus.rvalid   <= '0;
         bus.done     <= '0;
         bus.rdata    <= '0;
         bus.rword    <= '0;
         bus.mem_rd   <= 1'b0;
         bus.mem_addr <= '0;
      end else begin
         bus.rvalid <= '0;
         bus.done   <= '0;
         case (state_q)
            StIdle: begin
               if (|bus.req) begin
                  state_q      <= StBusy;
                  owner_q      <= win;
                  cnt_q        <= '0;
                  bus.mem_addr <= win ? bus.addr1 : bus.addr0;
                  bus.grant    <= {win, ~win};
                  bus.mem_rd   <= 1'b1;
               end
            end
            StBusy: begin
               if (bus.mem_ready) begin
                  bus.rdata  <= bus.mem_data;
                  bus.rword  <= cnt_q;
                  bus.rvalid <= {owner_q, ~owner_q};
                  if (cnt_q == LastWord) begin
                     state_q    <= StDone;
                     bus.done   <= {owner_q, ~owner_q};
                     bus.mem_rd <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + WSEL_W'(1);
                  end
               end
            end
            StDone: begin
               state_q   <= StIdle;
               last_q    <= owner_q;
               bus.grant <= '0;
            end
            default: begin
               state_q    <= StIdle;
               bus.grant  <= '0;
               bus.mem_rd <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_refill_arbiter.sv
// Randomised scoreboard bench for refill_arbiter: a burst-level model predicts the winner,
// latched address and delivered words; a negedge monitor checks every rvalid against the queue.
module tb_refill_arbiter;
   localparam int unsigned WORDS  = 4;
   localparam int unsigned WSEL_W = 2;

   typedef struct {
      int          owner;
      logic [31:0] data;
      int          word;
      bit          last;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   refill_arbiter_if #(.WSEL_W(WSEL_W)) bus ();

   refill_arbiter #(.WORDS(WORDS), .WSEL_W(WSEL_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   bit          mon_en   = 1'b0;
   bit          model_last;
   logic [31:0] last_rdata = '0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every cycle grant must be one-hot or zero, and rvalid/done appear only when due.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         check("grant_onehot", 64'($countones(bus.grant) <= 1), 64'd1);
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("rvalid", bus.rvalid, e.owner ? 2'b10 : 2'b01);
            check("rdata", bus.rdata, e.data);
            check("rword", bus.rword, e.word);
            check("done", bus.done, e.last ? (e.owner ? 2'b10 : 2'b01) : 2'b00);
            last_rdata = e.data;
         end else begin
            check("no_rvalid", bus.rvalid, 2'b00);
            check("no_done", bus.done, 2'b00);
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_grant"}, bus.grant, 0);
      check({tag, "_rvalid"}, bus.rvalid, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_mem_rd"}, bus.mem_rd, 0);
      check({tag, "_rdata"}, bus.rdata, 0);
      check({tag, "_rword"}, bus.rword, 0);
      check({tag, "_mem_addr"}, bus.mem_addr, 0);
      check({tag, "_mem_w_sel"}, bus.mem_w_sel, 0);
   endtask

   // One refill, entered at a negedge while the arbiter sits in IDLE.
   task automatic burst(input logic [1:0] pat, input logic [31:0] a0, input logic [31:0] a1,
                        input bit drop, input bit do_reset);
      int          w_exp;
      logic [31:0] a_exp;
      logic [1:0]  g_exp;
      logic [31:0] d;
      int          gap;
      if (pat == 2'b11) w_exp = model_last ? 0 : 1;
      else              w_exp = (pat == 2'b10) ? 1 : 0;
      a_exp = w_exp ? a1 : a0;
      g_exp = w_exp ? 2'b10 : 2'b01;

      bus.req   = pat;
      bus.addr0 = a0;
      bus.addr1 = a1;
      @(negedge clk);
      check("grant", bus.grant, g_exp);
      check("mem_rd_on", bus.mem_rd, 1);
      check("busy_on", bus.busy, 1);
      check("mem_addr", bus.mem_addr, a_exp);

      bus.addr0 = $urandom;
      bus.addr1 = drop ? 32'hFFFF_FFF0 : $urandom;
      if (drop) bus.req = 2'b00;

      for (int w = 0; w < int'(WORDS); w++) begin
         gap = $urandom_range(0, 2);
         repeat (gap) begin
            bus.mem_ready = 1'b0;
            @(negedge clk);
         end
         check("mem_rd_burst", bus.mem_rd, 1);
         check("mem_w_sel", bus.mem_w_sel, w);
         check("grant_hold", bus.grant, g_exp);
         check("mem_addr_hold", bus.mem_addr, a_exp);
         d = $urandom;
         bus.mem_ready = 1'b1;
         bus.mem_data  = d;
         exp_q.push_back('{owner: w_exp, data: d, word: w, last: (w == int'(WORDS) - 1),
                           due: cyc + 1});
         @(negedge clk);
         if (do_reset) begin
            reset         = 1'b1;
            bus.mem_ready = 1'b0;
            bus.req       = 2'b00;
            @(negedge clk);
            check_all_zero("mid_reset");
            reset      = 1'b0;
            model_last = 1'b1;
            last_rdata = '0;
            return;
         end
      end

      // DONE cycle: RAM strobe dropped, grant still held; a stray ready here must be ignored.
      check("mem_rd_done", bus.mem_rd, 0);
      check("grant_done", bus.grant, g_exp);
      check("busy_done", bus.busy, 1);
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.mem_data  = $urandom;
      bus.req       = 2'b00;
      model_last    = (w_exp != 0);
      @(negedge clk);
      check("grant_idle", bus.grant, 0);
      check("busy_idle", bus.busy, 0);
      check("mem_rd_idle", bus.mem_rd, 0);
      check("rdata_kept", bus.rdata, last_rdata);
      bus.mem_ready = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      bus.req       = 2'b00;
      bus.addr0     = '0;
      bus.addr1     = '0;
      bus.mem_ready = 1'b0;
      bus.mem_data  = '0;
      model_last    = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset  = 1'b0;
      mon_en = 1'b1;

      // Stray ready while idle: no rvalid, rdata untouched, stays idle.
      repeat (2) begin
         bus.mem_ready = 1'b1;
         bus.mem_data  = $urandom;
         @(negedge clk);
         check("spurious_grant", bus.grant, 0);
         check("spurious_busy", bus.busy, 0);
         check("spurious_rdata", bus.rdata, 0);
      end
      bus.mem_ready = 1'b0;

      burst(2'b01, 32'h0000_0040, 32'h0000_1000, 1'b0, 1'b0);
      burst(2'b11, 32'h0000_2000, 32'h0000_3000, 1'b0, 1'b1);
      // After reset requester 0 wins the tie, then strict alternation.
      repeat (4) burst(2'b11, {$urandom} & 32'hFFFF_FFF0, {$urandom} & 32'hFFFF_FFF0, 1'b0, 1'b0);
      burst(2'b10, 32'h0000_0100, 32'h0000_0200, 1'b1, 1'b0);

      repeat (30) begin
         burst(2'($urandom_range(1, 3)), {$urandom} & 32'hFFFF_FFF0, {$urandom} & 32'hFFFF_FFF0,
               1'($urandom_range(0, 1)), 1'b0);
      end

      repeat (2) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
